// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
// SPI mode 0 receive endpoint: oversamples sck/mosi/cs_n in the clk domain,
// deserialises MSB-first words and presents them on a valid/ready port.
// Ports:
//   clk, rst                   system clock, async active-high reset
//   sck, mosi, cs_n            raw SPI lines from the master
//   rx_data, rx_valid, rx_ready word output handshake
//   frame_err, overrun         1-cycle error pulses
//   active                     frame in progress
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              active
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic sck_q, cs_q;
  logic sck_s, mosi_s, cs_s;
  logic sck_rise, cs_rise, cs_fall;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              word_done;
  logic [DATA_W-1:0] word;

  // Synchronisers plus one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_q       <= sck_s;
      cs_q        <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign cs_fall  = ~cs_s & cs_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a cs_n rise wins over a coincident sck rise.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    active = (state_q == ACTIVE);
  end

  assign word = {shift_q[DATA_W-2:0], mosi_s};
  assign word_done = (state_q == ACTIVE) && !cs_rise && sck_rise &&
                     (bit_cnt_q == CW'(DATA_W-1));

  // Datapath next state.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (state_q == IDLE) begin
      if (cs_fall) begin
        shift_d   = '0;
        bit_cnt_d = '0;
      end
    end else if (cs_rise) begin
      // Partial word is dropped; output word is left untouched.
      frame_err_d = (bit_cnt_q != '0);
    end else if (sck_rise) begin
      shift_d = word;
      if (bit_cnt_q == CW'(DATA_W-1)) bit_cnt_d = '0;
      else                            bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (word_done) begin
      rx_data_d  = word;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave_rx: mode 0 SPI master model,
// scoreboard of expected words, pulse counters for error outputs.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       mosi;
  logic       cs_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       active;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int rd = 0;

  int hs_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int vld_cnt = 0;
  int act_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_rx #(.SYNC_STAGES(2), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .active    (active)
  );

  // Monitor: sampled on the falling edge, between input changes
  // (at 7 mod 10) and the rising edge that uses them.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        got_q.push_back(rx_data);
        hs_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (rx_valid)  vld_cnt++;
      if (active)    act_cnt++;
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input int nbytes);
    cs_n = 1'b0;
    #40;
    spi_bits(b0, 8);
    if (nbytes > 1) spi_bits(b1, 8);
    #40 cs_n = 1'b1;
    #80;
  endtask

  // Scoreboard drain: compare every expected word with what was seen.
  task automatic sb_drain(input string name);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd >= got_q.size()) begin
        n_err++;
        $display("FAIL %s missing word: got none, need %h", name, e);
      end else begin
        if (got_q[rd] !== e) begin
          n_err++;
          $display("FAIL %s word: got %h, need %h", name, got_q[rd], e);
        end
        rd++;
      end
    end
    n_cmp++;
    if (got_q.size() !== rd) begin
      n_err++;
      $display("FAIL %s extra words: got %0d, need %0d",
               name, got_q.size(), rd);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; rx_ready = 1'b0;
    #7;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, overrun, active} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_hold outs: got %h, need 000",
               {rx_data, rx_valid, frame_err, overrun, active});
    end
    #20 rst = 1'b0;
    #30;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, overrun, active} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_rel outs: got %h, need 000",
               {rx_data, rx_valid, frame_err, overrun, active});
    end
  endtask

  task automatic test_single;
    int f0, o0, h0;
    f0 = ferr_cnt; o0 = ovr_cnt; h0 = hs_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    spi_frame(8'hA5, 8'h00, 1);
    sb_drain("single");
    n_cmp++;
    if (hs_cnt - h0 !== 1) begin
      n_err++;
      $display("FAIL single hs: got %0d, need 1", hs_cnt - h0);
    end
    n_cmp++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      n_err++;
      $display("FAIL single errs: got %0d/%0d, need 0/0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_back_to_back;
    int h0;
    h0 = hs_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    spi_frame(8'hA5, 8'h3C, 2);
    sb_drain("b2b");
    n_cmp++;
    if (hs_cnt - h0 !== 2) begin
      n_err++;
      $display("FAIL b2b hs: got %0d, need 2", hs_cnt - h0);
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL b2b active: got %b, need 0", active);
    end
  endtask

  task automatic test_overrun;
    int o0, h0;
    o0 = ovr_cnt; h0 = hs_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h22);
    spi_frame(8'h11, 8'h22, 2);
    n_cmp++;
    if (ovr_cnt - o0 !== 1) begin
      n_err++;
      $display("FAIL ovr pulses: got %0d, need 1", ovr_cnt - o0);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      n_err++;
      $display("FAIL ovr hold: got %b/%h, need 1/22", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    #30;
    sb_drain("ovr");
    n_cmp++;
    if (hs_cnt - h0 !== 1 || rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr consume: got %0d/%b, need 1/0",
               hs_cnt - h0, rx_valid);
    end
  endtask

  task automatic test_frame_err;
    int f0, v0;
    f0 = ferr_cnt; v0 = vld_cnt;
    rx_ready = 1'b1;
    cs_n = 1'b0;
    #40;
    spi_bits(8'hFF, 5);
    #40 cs_n = 1'b1;
    #80;
    n_cmp++;
    if (ferr_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL ferr pulses: got %0d, need 1", ferr_cnt - f0);
    end
    n_cmp++;
    if (vld_cnt - v0 !== 0) begin
      n_err++;
      $display("FAIL ferr valid: got %0d, need 0", vld_cnt - v0);
    end
    exp_q.push_back(8'h3C);
    spi_frame(8'h3C, 8'h00, 1);
    sb_drain("ferr_next");
  endtask

  task automatic test_cs_high;
    int f0, o0, v0, a0;
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = vld_cnt; a0 = act_cnt;
    cs_n = 1'b1;
    spi_bits(8'hAA, 8);
    spi_bits(8'h55, 8);
    #80;
    n_cmp++;
    if (vld_cnt - v0 !== 0 || act_cnt - a0 !== 0) begin
      n_err++;
      $display("FAIL cshigh valid/active: got %0d/%0d, need 0/0",
               vld_cnt - v0, act_cnt - a0);
    end
    n_cmp++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      n_err++;
      $display("FAIL cshigh errs: got %0d/%0d, need 0/0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_mid_reset;
    int f0;
    rx_ready = 1'b0;
    spi_frame(8'h5A, 8'h00, 1);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
      n_err++;
      $display("FAIL rst_pre: got %b/%h, need 1/5a", rx_valid, rx_data);
    end
    cs_n = 1'b0;
    #40;
    spi_bits(8'hF0, 4);
    rst = 1'b1; cs_n = 1'b1;
    #1;
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, overrun, active} !== 12'h000) begin
      n_err++;
      $display("FAIL rst_mid outs: got %h, need 000",
               {rx_data, rx_valid, frame_err, overrun, active});
    end
    #19 rst = 1'b0;
    f0 = ferr_cnt;
    #40;
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    spi_frame(8'hC3, 8'h00, 1);
    sb_drain("rst_after");
    n_cmp++;
    if (ferr_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL rst_after ferr: got %0d, need 0", ferr_cnt - f0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overrun;
    test_frame_err;
    test_cs_high;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
